// File: rtl/sad_seq_cost_if.sv
// Handshake bundle for sad_seq_cost: window-pair input channel and cost
// output channel. Both channels use valid/ready: a beat transfers on a rising
// edge where valid and ready are both high; the producer holds its payload
// stable while valid is high and ready is low.
interface sad_seq_cost_if #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int COST_SIZE = 24,
  parameter int TAG_SIZE  = 8
);
  localparam int WIN_W = DATA_SIZE * WIN * WIN;

  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic [TAG_SIZE-1:0]  in_tag;
  logic [WIN_W-1:0]     in_a;
  logic [WIN_W-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [COST_SIZE-1:0] out_cost;
  logic                 out_mode;
  logic [TAG_SIZE-1:0]  out_tag;
  logic                 out_sat;

  // Window buffers plus min-select stage side.
  modport master (
    output in_valid, in_mode, in_tag, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_cost, out_mode, out_tag, out_sat
  );

  // Cost engine side.
  modport slave (
    input  in_valid, in_mode, in_tag, in_a, in_b, out_ready,
    output in_ready, out_valid, out_cost, out_mode, out_tag, out_sat
  );
endinterface

// File: rtl/sad_seq_cost.sv
// Sequential window cost engine: captures a window pair, folds it through
// LANES absolute/squared difference units per cycle, saturates the total to
// COST_SIZE bits and returns it with the pass-through tag.
module sad_seq_cost #(
  parameter int WIN       = 15,
  parameter int DATA_SIZE = 8,
  parameter int LANES     = 15,
  parameter int COST_SIZE = 24,
  parameter int TAG_SIZE  = 8
) (
  input  logic              clk,
  input  logic              rst,
  sad_seq_cost_if.slave     bus,
  output logic [1:0]        dbg_state
);
  localparam int WIN_SIZE = WIN * WIN;
  localparam int WIN_W    = DATA_SIZE * WIN_SIZE;
  localparam int N_CHUNKS = (WIN_SIZE + LANES - 1) / LANES;
  // Captured windows are zero padded to a whole number of chunks; padding
  // elements have a == b == 0 and so contribute nothing to either cost.
  localparam int PAD_W    = N_CHUNKS * LANES * DATA_SIZE;
  localparam int STEP_W   = LANES * DATA_SIZE;
  localparam int TERM_W   = 2 * DATA_SIZE;
  localparam int CHUNK_W  = TERM_W + $clog2(LANES + 1);
  localparam int ACC_W    = ((COST_SIZE + 1) > CHUNK_W ? (COST_SIZE + 1) : CHUNK_W) + 1;
  localparam int CNT_W    = $clog2(N_CHUNKS + 1);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);
  localparam logic [ACC_W-1:0] COST_MAX   = {{(ACC_W-COST_SIZE){1'b0}}, {COST_SIZE{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     chunk_q, chunk_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic [PAD_W-1:0]     a_q, a_d, b_q, b_d;
  logic                 mode_q, mode_d;
  logic [TAG_SIZE-1:0]  tag_q, tag_d;
  logic [COST_SIZE-1:0] out_cost_q, out_cost_d;
  logic [TAG_SIZE-1:0]  out_tag_q, out_tag_d;
  logic                 out_mode_q, out_mode_d;
  logic                 out_sat_q, out_sat_d;
  logic [CHUNK_W-1:0]   chunk_sum;
  logic [ACC_W-1:0]     acc_sum;

  // Difference lanes: the current chunk always sits in the low STEP_W bits.
  always_comb begin
    chunk_sum = '0;
    for (int l = 0; l < LANES; l++) begin : lane
      logic [DATA_SIZE-1:0] la, lb, ld;
      logic [TERM_W-1:0]    lt;
      la = a_q[l*DATA_SIZE +: DATA_SIZE];
      lb = b_q[l*DATA_SIZE +: DATA_SIZE];
      ld = (la >= lb) ? (la - lb) : (lb - la);
      lt = mode_q ? (TERM_W'(ld) * TERM_W'(ld)) : TERM_W'(ld);
      chunk_sum = chunk_sum + CHUNK_W'(lt);
    end
    acc_sum = acc_q + ACC_W'(chunk_sum);
  end

  // Next-state and datapath control; the accumulator is clamped once
  // saturated so it can never wrap during the remaining chunks.
  always_comb begin
    state_d    = state_q;
    chunk_d    = chunk_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    tag_d      = tag_q;
    out_cost_d = out_cost_q;
    out_tag_d  = out_tag_q;
    out_mode_d = out_mode_q;
    out_sat_d  = out_sat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = PAD_W'(bus.in_a);
          b_d     = PAD_W'(bus.in_b);
          mode_d  = bus.in_mode;
          tag_d   = bus.in_tag;
          acc_d   = '0;
          sat_d   = 1'b0;
          chunk_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        sat_d   = sat_q | (acc_sum > COST_MAX);
        acc_d   = sat_d ? COST_MAX : acc_sum;
        a_d     = a_q >> STEP_W;
        b_d     = b_q >> STEP_W;
        chunk_d = chunk_q + CNT_W'(1);
        if (chunk_q == LAST_CHUNK) begin
          out_cost_d = sat_d ? {COST_SIZE{1'b1}} : acc_sum[COST_SIZE-1:0];
          out_sat_d  = sat_d;
          out_tag_d  = tag_q;
          out_mode_d = mode_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      chunk_q    <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 1'b0;
      tag_q      <= '0;
      out_cost_q <= '0;
      out_tag_q  <= '0;
      out_mode_q <= 1'b0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      chunk_q    <= chunk_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      tag_q      <= tag_d;
      out_cost_q <= out_cost_d;
      out_tag_q  <= out_tag_d;
      out_mode_q <= out_mode_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_cost  = out_cost_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_sat   = out_sat_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_sad_seq_cost.sv
// Directed bench for sad_seq_cost at WIN=3, LANES=4 (three chunks, last one
// holding a single element) with a 16-bit cost so SSD saturation is reachable.
module tb_sad_seq_cost;
  localparam int WIN = 3, DATA_SIZE = 8, LANES = 4, COST_SIZE = 16, TAG_SIZE = 8;
  localparam int N_CHUNKS = 3;
  localparam int WIN_W = DATA_SIZE * WIN * WIN;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  sad_seq_cost_if #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .COST_SIZE(COST_SIZE),
                    .TAG_SIZE(TAG_SIZE)) bus ();

  sad_seq_cost #(.WIN(WIN), .DATA_SIZE(DATA_SIZE), .LANES(LANES),
                 .COST_SIZE(COST_SIZE), .TAG_SIZE(TAG_SIZE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] fill(input logic [7:0] v);
    logic [WIN_W-1:0] w;
    for (int r = 0; r < WIN * WIN; r++) w[r*DATA_SIZE +: DATA_SIZE] = v;
    return w;
  endfunction

  // Offer a window pair and return #1 after the accepting edge.
  task automatic send(input logic [WIN_W-1:0] a, input logic [WIN_W-1:0] b,
                      input logic m, input logic [7:0] t);
    int n;
    bus.in_a = a; bus.in_b = b; bus.in_mode = m; bus.in_tag = t;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // Scramble the inputs to show the captured copy is what gets used.
    bus.in_a = ~a; bus.in_b = a; bus.in_mode = ~m; bus.in_tag = ~t;
  endtask

  // Walk the fixed latency and check the result fields; optionally check the
  // output handshake completes on the following edge.
  task automatic expect_result(input string name, input logic [15:0] cost,
                               input logic sat, input logic m,
                               input logic [7:0] t, input bit hs);
    for (int e = 1; e <= N_CHUNKS; e++) begin
      @(posedge clk); #1;
      check({name, "_valid_edge"}, {31'd0, bus.out_valid}, (e == N_CHUNKS) ? 32'd1 : 32'd0);
      if (e < N_CHUNKS) check({name, "_busy"}, {31'd0, bus.in_ready}, 32'd0);
    end
    check({name, "_cost"}, {16'd0, bus.out_cost}, {16'd0, cost});
    check({name, "_sat"},  {31'd0, bus.out_sat},  {31'd0, sat});
    check({name, "_mode"}, {31'd0, bus.out_mode}, {31'd0, m});
    check({name, "_tag"},  {24'd0, bus.out_tag},  {24'd0, t});
    if (hs) begin
      @(posedge clk); #1;
      check({name, "_drop"},  {31'd0, bus.out_valid}, 32'd0);
      check({name, "_ready"}, {31'd0, bus.in_ready},  32'd1);
    end
  endtask

  // Directed stimulus sequence
  initial begin
    logic [WIN_W-1:0] ramp;
    for (int r = 0; r < WIN * WIN; r++) ramp[r*DATA_SIZE +: DATA_SIZE] = 8'(r);

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_tag = '0;
    bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_cost",  {16'd0, bus.out_cost},  32'd0);
    check("rst_out_tag",   {24'd0, bus.out_tag},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // SAD/SSD on uniform windows.
    send(fill(8'd10), fill(8'd7), 1'b0, 8'h5A);
    expect_result("sad_10_7", 16'd27, 1'b0, 1'b0, 8'h5A, 1'b1);
    send(fill(8'd10), fill(8'd7), 1'b1, 8'h5B);
    expect_result("ssd_10_7", 16'd81, 1'b0, 1'b1, 8'h5B, 1'b1);
    // Extremes: SAD fits, SSD saturates.
    send(fill(8'd255), fill(8'd0), 1'b0, 8'h01);
    expect_result("sad_max", 16'd2295, 1'b0, 1'b0, 8'h01, 1'b1);
    send(fill(8'd255), fill(8'd0), 1'b1, 8'h02);
    expect_result("ssd_sat", 16'd65535, 1'b1, 1'b1, 8'h02, 1'b1);
    // Ramp: element 8 lives alone in the last chunk.
    send(ramp, fill(8'd0), 1'b0, 8'h03);
    expect_result("ramp", 16'd36, 1'b0, 1'b0, 8'h03, 1'b1);
    // b > a direction on the ramp, SSD: sum (8-r)^2 = 204.
    send(fill(8'd0), fill(8'd8) - ramp, 1'b1, 8'h04);
    expect_result("ramp_ssd", 16'd204, 1'b0, 1'b1, 8'h04, 1'b1);

    // Back-pressure: hold DONE for five cycles with an ignored in_valid pulse.
    bus.out_ready = 1'b0;
    send(fill(8'd5), fill(8'd2), 1'b0, 8'h11);
    expect_result("stall", 16'd27, 1'b0, 1'b0, 8'h11, 1'b0);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus.in_valid = 1'b1; bus.in_a = fill(8'd99); bus.in_b = fill(8'd0);
        bus.in_tag = 8'hEE;
      end
      if (c == 2) bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      check("stall_cost",  {16'd0, bus.out_cost},  32'd27);
      check("stall_tag",   {24'd0, bus.out_tag},   32'h11);
      check("stall_busy",  {31'd0, bus.in_ready},  32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_drop",  {31'd0, bus.out_valid}, 32'd0);
    check("stall_ready", {31'd0, bus.in_ready},  32'd1);
    send(fill(8'd2), fill(8'd6), 1'b1, 8'h22);
    expect_result("after_stall", 16'd144, 1'b0, 1'b1, 8'h22, 1'b1);

    // Reset in the middle of ACCUM after chunk 1.
    send(fill(8'd200), fill(8'd0), 1'b1, 8'h77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_cost",  {16'd0, bus.out_cost},  32'd0);
    check("mid_rst_tag",   {24'd0, bus.out_tag},   32'd0);
    check("mid_rst_mode",  {31'd0, bus.out_mode},  32'd0);
    check("mid_rst_ready", {31'd0, bus.in_ready},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {31'd0, bus.in_ready},  32'd1);
    check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    send(fill(8'd3), fill(8'd1), 1'b0, 8'h33);
    expect_result("post_rst", 16'd18, 1'b0, 1'b0, 8'h33, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
